// File: rtl/dac_serial_transmitter.sv
// I2S serializer for the audio DAC: one stereo pair per 2*WIDTH-bit frame, MSB first,
// with the standard one-bit delay. All state changes on the falling edge of the bit clock.
module dac_serial_transmitter #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] left_data,
  input  logic [WIDTH-1:0] right_data,
  output logic             lrclk,
  output logic             sd
);

  localparam int KW = $clog2(2 * WIDTH);
  localparam int IW = $clog2(WIDTH);
  localparam logic [KW-1:0] K_LAST = KW'(2 * WIDTH - 1);
  localparam logic [KW-1:0] K_HALF = KW'(WIDTH);

  logic [KW-1:0]    k;
  logic [KW-1:0]    k_next;
  logic [WIDTH-1:0] l_hold;
  logic [WIDTH-1:0] r_hold;
  logic [IW-1:0]    l_idx;
  logic [IW-1:0]    r_idx;
  logic             lrclk_next;
  logic             sd_next;

  // Output values are computed from the post-increment bit position, so the
  // registered outputs always describe the slot the DAC samples next.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    k_next     = (k == K_LAST) ? '0 : k + KW'(1);
    l_idx      = IW'(K_HALF - k_next);
    r_idx      = IW'(K_HALF - (k_next - K_HALF));
    lrclk_next = (k_next >= K_HALF);
    sd_next    = 1'b0;
    if (k_next == '0) begin
      // The held right word is still the previous frame's here: its LSB is the delayed bit.
      sd_next = r_hold[0];
    end else if (k_next <= K_HALF) begin
      sd_next = l_hold[l_idx];
    end else begin
      sd_next = r_hold[r_idx];
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so all of them see pre-edge values.
    if (rst) begin
      k      <= K_LAST;
      lrclk  <= 1'b0;
      sd     <= 1'b0;
      l_hold <= '0;
      r_hold <= '0;
    end else if (!enable) begin
      // Holding registers keep their contents so the delayed R LSB survives an idle gap.
      k     <= K_LAST;
      lrclk <= 1'b0;
      sd    <= 1'b0;
    end else begin
      k     <= k_next;
      lrclk <= lrclk_next;
      sd    <= sd_next;
      if (k_next == '0) begin
        l_hold <= left_data;
        r_hold <= right_data;
      end
    end
  end

endmodule

// File: tb/tb_dac_serial_transmitter.sv
// Directed bench for dac_serial_transmitter: a frame-level stream model checked every bit
// clock, plus hand-computed frame captures for reset, framing, capture and enable behaviour.
module tb_dac_serial_transmitter;

  localparam int W = 24;
  localparam int F = 2 * W;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [W-1:0] left_data;
  logic [W-1:0] right_data;
  logic         lrclk;
  logic         sd;

  int n_checks = 0;
  int n_pass   = 0;

  dac_serial_transmitter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .left_data  (left_data),
    .right_data (right_data),
    .lrclk      (lrclk),
    .sd         (sd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [F-1:0] act, input logic [F-1:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Stream model: at each frame start the whole serial word is assembled as
  // {previous R LSB, L, R without its LSB}, then read out one position per clock.
  int           m_pos;
  logic [F-1:0] m_frame;
  logic         m_r0;
  logic         exp_lr;
  logic         exp_sd;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_pos  = F - 1;
      m_frame = '0;
      m_r0   = 1'b0;
      exp_lr = 1'b0;
      exp_sd = 1'b0;
    end else if (!enable) begin
      m_pos  = F - 1;
      exp_lr = 1'b0;
      exp_sd = 1'b0;
    end else begin
      m_pos = (m_pos + 1) % F;
      if (m_pos == 0) begin
        m_frame = {m_r0, left_data, right_data[W-1:1]};
        m_r0    = right_data[0];
      end
      exp_sd = m_frame[F-1-m_pos];
      exp_lr = (m_pos >= W);
    end
  end

  logic model_on = 1'b0;
  always @(posedge clk) begin
    if (model_on) begin
      check("model_lrclk", F'(lrclk), F'(exp_lr));
      check("model_sd", F'(sd), F'(exp_sd));
    end
  end

  // Samples k = 0..F-1 of one frame; bit F-1 of each vector is k = 0. An optional
  // action is applied right after sampling position act_at.
  task automatic grab_frame(input int act_at, input int act_kind, input logic [W-1:0] val,
                            output logic [F-1:0] bits, output logic [F-1:0] lrs);
    for (int i = 0; i < F; i++) begin
      @(posedge clk);
      #1;
      bits[F-1-i] = sd;
      lrs[F-1-i]  = lrclk;
      if (i == act_at) begin
        if (act_kind == 1) left_data = val;
        else if (act_kind == 2) enable = 1'b0;
      end
    end
  endtask

  localparam logic [F-1:0] LR_PATTERN = {{W{1'b0}}, {W{1'b1}}};

  logic [F-1:0] bits;
  logic [F-1:0] lrs;

  initial begin
    rst = 1'b1; enable = 1'b0; left_data = '0; right_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_lrclk", F'(lrclk), '0);
    check("reset_sd", F'(sd), '0);
    model_on   = 1'b1;
    left_data  = 24'hA5A5A5;
    right_data = 24'h123456;
    enable     = 1'b1;
    rst        = 1'b0;

    // Frame 1: basic serialization
    grab_frame(-1, 0, '0, bits, lrs);
    check("f1_k0_after_reset", F'(bits[F-1]), '0);
    check("f1_left", F'(bits[F-2:W-1]), F'(24'hA5A5A5));
    check("f1_right_msbs", F'(bits[W-2:0]), F'(23'h091A2B));
    check("f1_lrclk", lrs, LR_PATTERN);

    // Frame 2: left changes mid-frame, must not disturb this frame
    grab_frame(10, 1, 24'hFFFFFF, bits, lrs);
    check("f2_k0_r_lsb", F'(bits[F-1]), '0);
    check("f2_left_isolated", F'(bits[F-2:W-1]), F'(24'hA5A5A5));
    grab_frame(-1, 0, '0, bits, lrs);
    check("f3_left_new", F'(bits[F-2:W-1]), F'(24'hFFFFFF));

    // Extremes
    left_data  = 24'h800000;
    right_data = 24'h7FFFFF;
    grab_frame(-1, 0, '0, bits, lrs);
    check("f4_left_min", F'(bits[F-2:W-1]), F'(24'h800000));
    check("f4_right_max", F'(bits[W-2:0]), F'(23'h3FFFFF));

    // Frame 5: delayed R LSB, then enable dropped at k = 30
    grab_frame(30, 2, '0, bits, lrs);
    check("f5_k0_r_lsb", F'(bits[F-1]), F'(1'b1));
    check("f5_left", F'(bits[F-2:W-1]), F'(24'h800000));
    check("f5_sd_after_drop", F'(bits[16:0]), '0);
    check("f5_lrclk_after_drop", F'(lrs[16:0]), '0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("idle_lrclk", F'(lrclk), '0);
      check("idle_sd", F'(sd), '0);
    end

    // Re-enable: fresh frame with capture; stored R LSB (1) retained across idle
    left_data  = 24'h3C3C3C;
    right_data = 24'hC3C3C3;
    enable     = 1'b1;
    grab_frame(-1, 0, '0, bits, lrs);
    check("f6_k0_retained", F'(bits[F-1]), F'(1'b1));
    check("f6_left", F'(bits[F-2:W-1]), F'(24'h3C3C3C));
    check("f6_right_msbs", F'(bits[W-2:0]), F'(23'h61E1E1));
    check("f6_lrclk", lrs, LR_PATTERN);

    // Framing over 10 frames
    for (int f = 0; f < 10; f++) begin
      grab_frame(-1, 0, '0, bits, lrs);
      check("framing_lrclk", lrs, LR_PATTERN);
    end

    // Asynchronous reset mid-stream (at k = 47, lrclk high)
    check("pre_reset_lrclk", F'(lrclk), F'(1'b1));
    check("pre_reset_sd", F'(sd), F'(1'b1));
    rst = 1'b1;
    #1;
    check("async_reset_lrclk", F'(lrclk), '0);
    check("async_reset_sd", F'(sd), '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    grab_frame(-1, 0, '0, bits, lrs);
    check("post_reset_k0", F'(bits[F-1]), '0);
    check("post_reset_left", F'(bits[F-2:W-1]), F'(24'h3C3C3C));
    check("post_reset_lrclk", lrs, LR_PATTERN);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
